// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone classic arbiter with cyc-based locking.
// Optional watchdog: define WBARB_TIMEOUT_EN to abort stalled owners after TIMEOUT cycles.
module wb_arbiter2 #(
  parameter int AWIDTH  = 15,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [AWIDTH-1:0] m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [AWIDTH-1:0] m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [AWIDTH-1:0] s_adr_o,
  output logic [31:0]       s_dat_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i
);
  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic g0, g1, req0, req1, expire;
  assign g0 = state_q == S_GNT0;
  assign g1 = state_q == S_GNT1;
`ifdef WBARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] blk_q, blk_d;
  // an aborted owner stays blocked until it drops cyc once
  assign req0 = m0_cyc_i && !blk_q[0];
  assign req1 = m1_cyc_i && !blk_q[1];
  assign expire = s_stb_o && !s_ack_i && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    cnt_d = (state_d != state_q || s_ack_i || state_q == S_IDLE) ? '0 : s_stb_o ? cnt_q + 1'b1 : cnt_q;
    blk_d[0] = m0_cyc_i && (blk_q[0] || (expire && g0));
    blk_d[1] = m1_cyc_i && (blk_q[1] || (expire && g1));
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  assign m0_err_o = expire && g0;
  assign m1_err_o = expire && g1;
`else
  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i;
  assign expire = 1'b0 && (TIMEOUT > 0);
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    if (expire) begin
      state_d = S_IDLE;
      last_d = g1;
    end else if (state_q == S_IDLE)
      state_d = (req0 && (!req1 || last_q)) ? S_GNT0 : req1 ? S_GNT1 : S_IDLE;
    else if (g0 && !m0_cyc_i) begin
      last_d = 1'b0;
      state_d = req1 ? S_GNT1 : S_IDLE;
    end else if (g1 && !m1_cyc_i) begin
      last_d = 1'b1;
      state_d = req0 ? S_GNT0 : S_IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
    end
  assign s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign m0_ack_o = g0 && s_ack_i;
  assign m1_ack_o = g1 && s_ack_i;
  assign m0_dat_o = g0 ? s_dat_i : '0;
  assign m1_dat_o = g1 ? s_dat_i : '0;
endmodule
